// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// master = operand source / result sink, slave = the adder.
interface pipelined_cla_addsub_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         cin;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, A, B, cin, op, out_ready,
    input  in_ready, out_valid, Sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, A, B, cin, op, out_ready,
    output in_ready, out_valid, Sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per
// stage, operands skewed through the pipe, valid/ready with full backpressure.

module cla_group #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W-1:0] p, g, c;
  logic         grp_g, grp_p;

  // Every carry is a flat sum of products of g/p/ci; no carry feeds another.
  always_comb begin
    logic run_p, acc;
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < W - 1; i++) begin
      acc   = 1'b0;
      run_p = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc   = acc | (g[j] & run_p);
        run_p = run_p & p[j];
      end
      c[i+1] = acc | (run_p & ci);
    end
    acc   = 1'b0;
    run_p = 1'b1;
    for (int j = W - 1; j >= 0; j--) begin
      acc   = acc | (g[j] & run_p);
      run_p = run_p & p[j];
    end
    grp_g = acc;
    grp_p = run_p;
    s     = p ^ c;
    co    = grp_g | (grp_p & ci);
  end
endmodule

module pipelined_cla_addsub #(
  parameter int N     = 16,
  parameter int BLOCK = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pipelined_cla_addsub_if.slave  bus
);
  localparam int STAGES = N / BLOCK;

  logic              en;
  logic [STAGES:0]   vld_pipe_d, vld_pipe_q;
  logic [N-1:0]      in_a_d, in_a_q, in_b_d, in_b_q;
  logic              in_c_d, in_c_q;
  logic [N-1:0]      sum_d, sum_q;
  logic              cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;

  assign en            = ~vld_pipe_q[STAGES] | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_pipe_q[STAGES];
  assign bus.Sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (en) vld_pipe_d = {vld_pipe_q[STAGES-1:0], bus.in_valid};
  end

  // Subtract folds into add: A + ~B + ~cin.
  always_comb begin
    in_a_d = in_a_q;
    in_b_d = in_b_q;
    in_c_d = in_c_q;
    if (en & bus.in_valid) begin
      in_a_d = bus.A;
      in_b_d = bus.op ? ~bus.B : bus.B;
      in_c_d = bus.op ^ bus.cin;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      in_a_q     <= '0;
      in_b_q     <= '0;
      in_c_q     <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      in_a_q     <= in_a_d;
      in_b_q     <= in_b_d;
      in_c_q     <= in_c_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO  = k * BLOCK;
    localparam int REM = N - LO;

    logic [REM-1:0]      src_a, src_b;
    logic                src_c, ld, c_out;
    logic [BLOCK-1:0]    s_grp;
    logic [LO+BLOCK-1:0] sum_cat;

    assign ld = en & vld_pipe_q[k];

    if (k == 0) begin : g_src
      assign src_a   = in_a_q;
      assign src_b   = in_b_q;
      assign src_c   = in_c_q;
      assign sum_cat = s_grp;
    end else begin : g_src
      assign src_a   = stg[k-1].g_reg.a_q;
      assign src_b   = stg[k-1].g_reg.b_q;
      assign src_c   = stg[k-1].g_reg.c_q;
      assign sum_cat = {s_grp, stg[k-1].g_reg.sum_q};
    end

    cla_group #(.W(BLOCK)) u_grp (
      .a  (src_a[BLOCK-1:0]),
      .b  (src_b[BLOCK-1:0]),
      .ci (src_c),
      .s  (s_grp),
      .co (c_out)
    );

    if (k < STAGES - 1) begin : g_reg
      logic [REM-BLOCK-1:0] a_d, a_q, b_d, b_q;
      logic [LO+BLOCK-1:0]  sum_d, sum_q;
      logic                 c_d, c_q;

      always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        sum_d = sum_q;
        if (ld) begin
          a_d   = src_a[REM-1:BLOCK];
          b_d   = src_b[REM-1:BLOCK];
          c_d   = c_out;
          sum_d = sum_cat;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_q   <= '0;
          b_q   <= '0;
          c_q   <= 1'b0;
          sum_q <= '0;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          c_q   <= c_d;
          sum_q <= sum_d;
        end
      end
    end else begin : g_out
      // Carry into the MSB is recovered as s^a^b at that bit.
      always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (ld) begin
          sum_d  = sum_cat;
          cout_d = c_out;
          ovf_d  = s_grp[BLOCK-1] ^ src_a[BLOCK-1] ^ src_b[BLOCK-1] ^ c_out;
          zero_d = ~|sum_cat;
        end
      end
    end
  end
endmodule
